cc_tag_wctl: RTL and testbench



---
 rtl/cc_tag_wctl.sv | 208 ++++++++++++++++++++
 tb/tb_cc_tag_wctl.sv | 462 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_tag_wctl.sv
// cc_tag_wctl: write-side controller for one set of ccTag ways.
// Option CC_TAGWCTL_AUTOINIT_EN: run the init sweep out of reset.
module cc_tag_wctl #(
  parameter int WAYS       = 4,
  parameter int EXPQ_DEPTH = 4,
  parameter int RETRY_MAX  = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill_valid,
  input  logic [36:0]        fill_paddr,
  output logic               fill_ready,
  input  logic               inv_valid,
  input  logic [36:0]        inv_paddr,
  output logic               inv_ready,
  input  logic               init_req,
  output logic [36:0]        tag_write_phys_addr,
  output logic               tag_write_wen,
  output logic               tag_invalidate,
  output logic               tag_init,
  input  logic [WAYS-1:0]    tag_write_hit,
  input  logic [WAYS-1:0]    tag_exp_en,
  input  logic [WAYS*37-1:0] tag_expun_addr,
  output logic               exp_valid,
  output logic [36:0]        exp_addr,
  input  logic               exp_ready,
  output logic               drop,
  output logic               multi_hit,
  output logic               init_done
);

  localparam int AW = 37;
  localparam int PW = $clog2(EXPQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RETRY_MAX + 1);
  localparam int IW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } st_t;

`ifdef CC_TAGWCTL_AUTOINIT_EN
  localparam st_t  RST_ST   = S_INIT;
  localparam logic RST_INIT = 1'b1;
`else
  localparam st_t  RST_ST   = S_IDLE;
  localparam logic RST_INIT = 1'b0;
`endif

  st_t           st;
  logic          rdy_q;
  logic          inv_q;
  logic          pend;
  logic [5:0]    set_cnt;
  logic [RW-1:0] retry;

  logic [AW-1:0] mem [EXPQ_DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] q_cnt;
  logic [CW-1:0] cnt_n;

  logic          hit_any;
  logic          found;
  logic [IW-1:0] low;
  logic          push;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic          room_n;
  logic          pend_n;
  logic          inv_acc;
  logic          fill_acc;

  assign inv_ready  = rdy_q;
  assign fill_ready = rdy_q & ~inv_valid;
  assign inv_acc    = inv_valid & rdy_q;
  assign fill_acc   = fill_valid & fill_ready;

  assign exp_valid = (q_cnt != '0);
  assign exp_addr  = exp_valid ? mem[rp] : '0;

  assign hit_any   = |tag_write_hit;
  assign push      = (st == S_WAIT) & hit_any
                   & tag_exp_en[low];
  assign pop       = exp_valid & exp_ready;
  assign push_addr = tag_expun_addr[int'(low)*AW +: AW];
  assign cnt_n     = q_cnt + CW'(push) - CW'(pop);
  assign room_n    = (cnt_n < CW'(EXPQ_DEPTH));
  assign pend_n    = pend | init_req;

  // Lowest-numbered hitting way owns the expunge.
  always_comb begin
    low   = '0;
    found = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!found && tag_write_hit[i]) begin
        low   = IW'(i);
        found = 1'b1;
      end
    end
  end

  // Expunge queue storage.
  always_ff @(negedge clk) begin
    if (push) mem[wp] <= push_addr;
  end

  // Expunge queue pointers and occupancy.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      q_cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      q_cnt <= cnt_n;
    end
  end

  // Request / retry / init sequencer.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      st                  <= RST_ST;
      tag_init            <= RST_INIT;
      init_done           <= ~RST_INIT;
      rdy_q               <= 1'b0;
      tag_write_wen       <= 1'b0;
      tag_invalidate      <= 1'b0;
      tag_write_phys_addr <= '0;
      drop                <= 1'b0;
      multi_hit           <= 1'b0;
      inv_q               <= 1'b0;
      pend                <= 1'b0;
      set_cnt             <= '0;
      retry               <= '0;
    end else begin
      tag_write_wen  <= 1'b0;
      tag_invalidate <= 1'b0;
      drop           <= 1'b0;
      if (init_req && st != S_IDLE)
        pend <= 1'b1;
      if (st == S_WAIT &&
          $countones(tag_write_hit) > 1)
        multi_hit <= 1'b1;
      unique case (st)
        S_INIT: begin
          if (set_cnt == 6'd63) begin
            st        <= S_IDLE;
            tag_init  <= 1'b0;
            init_done <= 1'b1;
            rdy_q     <= room_n & ~pend_n;
          end else begin
            set_cnt <= set_cnt + 6'd1;
            tag_write_phys_addr <=
              {31'b0, set_cnt + 6'd1};
          end
        end
        S_IDLE: begin
          if (inv_acc || fill_acc) begin
            st             <= S_ISSUE;
            rdy_q          <= 1'b0;
            tag_write_wen  <= 1'b1;
            tag_invalidate <= inv_acc;
            inv_q          <= inv_acc;
            retry          <= '0;
            tag_write_phys_addr <=
              inv_acc ? inv_paddr : fill_paddr;
            if (init_req) pend <= 1'b1;
          end else if (pend_n) begin
            st                  <= S_INIT;
            rdy_q               <= 1'b0;
            tag_init            <= 1'b1;
            init_done           <= 1'b0;
            set_cnt             <= '0;
            tag_write_phys_addr <= '0;
            pend                <= 1'b0;
          end else begin
            rdy_q <= init_done & room_n;
          end
        end
        S_ISSUE: begin
          st    <= S_WAIT;
          rdy_q <= 1'b0;
        end
        S_WAIT: begin
          if (hit_any) begin
            st    <= S_IDLE;
            rdy_q <= init_done & room_n & ~pend_n;
          end else if (retry < RW'(RETRY_MAX)) begin
            st             <= S_ISSUE;
            retry          <= retry + 1'b1;
            tag_write_wen  <= 1'b1;
            tag_invalidate <= inv_q;
          end else begin
            st    <= S_IDLE;
            drop  <= 1'b1;
            rdy_q <= init_done & room_n & ~pend_n;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cc_tag_wctl.sv
// tb_cc_tag_wctl: vectors, corner sequences and random traffic
// against a queue-based reference model of cc_tag_wctl.
module tb_cc_tag_wctl;

  logic         clk;
  logic         rst;
  logic         fill_valid;
  logic [36:0]  fill_paddr;
  logic         fill_ready;
  logic         inv_valid;
  logic [36:0]  inv_paddr;
  logic         inv_ready;
  logic         init_req;
  logic [36:0]  tag_write_phys_addr;
  logic         tag_write_wen;
  logic         tag_invalidate;
  logic         tag_init;
  logic [3:0]   tag_write_hit;
  logic [3:0]   tag_exp_en;
  logic [147:0] tag_expun_addr;
  logic         exp_valid;
  logic [36:0]  exp_addr;
  logic         exp_ready;
  logic         drop;
  logic         multi_hit;
  logic         init_done;

  int n_cmp = 0;
  int n_fail = 0;

  cc_tag_wctl dut (
    .clk                 (clk),
    .rst                 (rst),
    .fill_valid          (fill_valid),
    .fill_paddr          (fill_paddr),
    .fill_ready          (fill_ready),
    .inv_valid           (inv_valid),
    .inv_paddr           (inv_paddr),
    .inv_ready           (inv_ready),
    .init_req            (init_req),
    .tag_write_phys_addr (tag_write_phys_addr),
    .tag_write_wen       (tag_write_wen),
    .tag_invalidate      (tag_invalidate),
    .tag_init            (tag_init),
    .tag_write_hit       (tag_write_hit),
    .tag_exp_en          (tag_exp_en),
    .tag_expun_addr      (tag_expun_addr),
    .exp_valid           (exp_valid),
    .exp_addr            (exp_addr),
    .exp_ready           (exp_ready),
    .drop                (drop),
    .multi_hit           (multi_hit),
    .init_done           (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          inv;
    logic [36:0] addr;
    logic [3:0]  hit;
    logic [3:0]  en;
    logic [36:0] xb;
    bit          e_push;
    logic [36:0] e_xaddr;
    bit          e_multi;
  } vec_t;

  vec_t vt [7];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
  endtask

  task automatic smp();
    #1;
  endtask

  function automatic logic [36:0] rnd37();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[36:0];
  endfunction

  function automatic int lowest(logic [3:0] h);
    for (int i = 0; i < 4; i++)
      if (h[i]) return i;
    return -1;
  endfunction

  task automatic set_exp(input logic [36:0] xb);
    tag_expun_addr = {xb + 37'd3, xb + 37'd2,
                      xb + 37'd1, xb};
  endtask

  // One request; ends in the cycle after the
  // tag response edge.
  task automatic txn(input bit inv,
                     input logic [36:0] a,
                     input logic [3:0] h,
                     input logic [3:0] en,
                     input logic [36:0] xb);
    tick();
    if (inv) begin
      inv_valid = 1'b1;
      inv_paddr = a;
    end else begin
      fill_valid = 1'b1;
      fill_paddr = a;
    end
    smp();
    chk("acc_rdy", inv ? inv_ready : fill_ready, 1);
    tick();
    fill_valid    = 1'b0;
    inv_valid     = 1'b0;
    tag_write_hit = h;
    tag_exp_en    = en;
    set_exp(xb);
    smp();
    chk("issue_wen", tag_write_wen, 1);
    chk("issue_addr", tag_write_phys_addr, a);
    chk("issue_inv", tag_invalidate, inv);
    tick();
    smp();
    chk("wait_wen", tag_write_wen, 0);
    chk("wait_rdy", inv_ready, 0);
    tick();
    tag_write_hit = 4'b0;
    smp();
  endtask

  task automatic run_vec(input vec_t v);
    txn(v.inv, v.addr, v.hit, v.en, v.xb);
    chk("vec_expv", exp_valid, v.e_push);
    if (v.e_push)
      chk("vec_expa", exp_addr, v.e_xaddr);
    chk("vec_rdy3", fill_ready, 1);
    chk("vec_multi", multi_hit, v.e_multi);
    if (v.e_push) begin
      exp_ready = 1'b1;
      tick();
      exp_ready = 1'b0;
      smp();
      chk("vec_pop", exp_valid, 0);
    end
  endtask

  initial begin
    int n;
    bit ok;
    bit rdy_at_drop;
    int n_wen;
    int n_drop;
    logic [36:0] mq [$];
    bit busy, m_multi, stubborn, resp_now;
    bit wen_e, drop_e, rdy_e;
    bit nx_wen, nx_drop;
    logic [36:0] r_addr;
    bit r_inv;
    int tries;
    int lw;
    int r;

    vt[0] = '{0, 37'h1234, 4'b0100, 4'b0000,
              37'h0, 0, 37'h0, 0};
    vt[1] = '{0, 37'h0AB0, 4'b0010, 4'b0010,
              37'h0776, 1, 37'h0777, 0};
    vt[2] = '{1, 37'h5555, 4'b1000, 4'b1000,
              37'h1000, 1, 37'h1003, 0};
    vt[3] = '{0, 37'h1F_FFFF_FFFF, 4'b0001,
              4'b0001, 37'h1A_BCDE_F010, 1,
              37'h1A_BCDE_F010, 0};
    vt[4] = '{0, 37'h0042, 4'b1010, 4'b1000,
              37'h200, 0, 37'h0, 1};
    vt[5] = '{1, 37'h0099, 4'b0110, 4'b0010,
              37'h300, 1, 37'h301, 1};
    vt[6] = '{0, 37'h0, 4'b1111, 4'b1111,
              37'h400, 1, 37'h400, 1};

    rst = 1'b1;
    fill_valid = 0; fill_paddr = '0;
    inv_valid = 0; inv_paddr = '0;
    init_req = 0; exp_ready = 0;
    tag_write_hit = '0; tag_exp_en = '0;
    tag_expun_addr = '0;

    tick(); tick(); smp();
    chk("rst_fill_rdy", fill_ready, 0);
    chk("rst_inv_rdy", inv_ready, 0);
    chk("rst_wen", tag_write_wen, 0);
    chk("rst_inv", tag_invalidate, 0);
    chk("rst_expv", exp_valid, 0);
    chk("rst_expa", exp_addr, 0);
    chk("rst_drop", drop, 0);
    chk("rst_multi", multi_hit, 0);
    chk("rst_addr", tag_write_phys_addr, 0);
`ifdef CC_TAGWCTL_AUTOINIT_EN
    chk("rst_tinit", tag_init, 1);
    chk("rst_idone", init_done, 0);
`else
    chk("rst_tinit", tag_init, 0);
    chk("rst_idone", init_done, 1);
`endif
    @(negedge clk);
    #2 rst = 1'b0;

`ifndef CC_TAGWCTL_AUTOINIT_EN
    tick();
    init_req = 1'b1;
    smp();
`endif
    n = 0;
    ok = 1;
    for (int c = 0; c < 100; c++) begin
      tick();
      init_req = 1'b0;
      smp();
      if (!tag_init) break;
      if (init_done) ok = 0;
      if (tag_write_phys_addr != 37'(n)) ok = 0;
      n++;
    end
    chk("init_len", n, 64);
    chk("init_seq", ok, 1);
    chk("init_done", init_done, 1);
    chk("init_inv_rdy", inv_ready, 1);

    foreach (vt[i]) run_vec(vt[i]);

    // Never hit: 16 issues then a drop.
    tick();
    fill_valid = 1'b1;
    fill_paddr = 37'h3C3C;
    tag_write_hit = 4'b0;
    smp();
    tick();
    fill_valid = 1'b0;
    n_wen = 0;
    n_drop = 0;
    ok = 1;
    rdy_at_drop = 0;
    for (int c = 0; c < 45; c++) begin
      smp();
      if (tag_write_wen) begin
        n_wen++;
        if (tag_write_phys_addr != 37'h3C3C)
          ok = 0;
      end
      if (drop) begin
        n_drop++;
        rdy_at_drop = inv_ready;
      end
      tick();
    end
    smp();
    chk("drop_wens", n_wen, 16);
    chk("drop_pulses", n_drop, 1);
    chk("drop_addr", ok, 1);
    chk("drop_rdy", rdy_at_drop, 1);
    chk("drop_noexp", exp_valid, 0);

    // Fill the queue, then contend with both valids.
    exp_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      txn(0, 37'h700 + 37'(k), 4'b0001, 4'b0001,
          37'h7100 + 37'(16 * k));
    chk("qf_fill_rdy", fill_ready, 0);
    chk("qf_inv_rdy", inv_ready, 0);
    chk("qf_head", exp_addr, 37'h7100);
    tick();
    fill_valid = 1'b1;
    fill_paddr = 37'h800;
    inv_valid  = 1'b1;
    inv_paddr  = 37'h900;
    smp();
    for (int j = 0; j < 3; j++) begin
      chk("qf_hold_inv", inv_ready, 0);
      chk("qf_hold_fill", fill_ready, 0);
      chk("qf_hold_wen", tag_write_wen, 0);
      tick();
      smp();
    end
    exp_ready = 1'b1;
    tick();
    exp_ready = 1'b0;
    smp();
    chk("qf_head2", exp_addr, 37'h7110);
    chk("qf_inv_rdy2", inv_ready, 1);
    chk("qf_fill_gate", fill_ready, 0);
    tick();
    inv_valid = 1'b0;
    tag_write_hit = 4'b0001;
    tag_exp_en = 4'b0000;
    smp();
    chk("pri_wen", tag_write_wen, 1);
    chk("pri_inv", tag_invalidate, 1);
    chk("pri_addr", tag_write_phys_addr, 37'h900);
    tick(); smp();
    tick(); smp();
    chk("pri_fill_rdy", fill_ready, 1);
    tick();
    fill_valid = 1'b0;
    smp();
    chk("pri2_wen", tag_write_wen, 1);
    chk("pri2_inv", tag_invalidate, 0);
    chk("pri2_addr", tag_write_phys_addr, 37'h800);
    tick(); smp();
    tick();
    tag_write_hit = 4'b0;
    smp();
    exp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      chk("drain_v", exp_valid, 1);
      chk("drain_a", exp_addr,
          37'h7110 + 37'(16 * j));
      tick();
      smp();
    end
    exp_ready = 1'b0;
    chk("drain_empty", exp_valid, 0);

    // Reset while a request waits, two queued.
    txn(0, 37'hA0, 4'b0100, 4'b0100, 37'hA00);
    txn(1, 37'hA1, 4'b0001, 4'b0001, 37'hA10);
    chk("rq_two", exp_valid, 1);
    tick();
    fill_valid = 1'b1;
    fill_paddr = 37'hA2;
    smp();
    tick();
    fill_valid = 1'b0;
    smp();
    tick();
    smp();
    #1 rst = 1'b1;
    #1;
    chk("ar_expv", exp_valid, 0);
    chk("ar_expa", exp_addr, 0);
    chk("ar_wen", tag_write_wen, 0);
    chk("ar_rdy", inv_ready, 0);
    chk("ar_multi", multi_hit, 0);
    chk("ar_addr", tag_write_phys_addr, 0);
    tick(); tick();
    @(negedge clk);
    #2 rst = 1'b0;
    exp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      smp();
      chk("ar_flushed", exp_valid, 0);
    end
    exp_ready = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      smp();
      if (inv_ready) break;
    end
    chk("rand_start", inv_ready, 1);

    // Random traffic against the reference model.
    busy = 0; m_multi = 0; stubborn = 0;
    resp_now = 0; wen_e = 0; drop_e = 0;
    r_addr = '0; r_inv = 0; tries = 0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      fill_valid = ($urandom_range(0, 2) == 0);
      fill_paddr = rnd37();
      inv_valid  = ($urandom_range(0, 4) == 0);
      inv_paddr  = rnd37();
      exp_ready  = $urandom_range(0, 1) != 0;
      tag_exp_en = 4'($urandom());
      for (int w = 0; w < 4; w++)
        tag_expun_addr[w*37 +: 37] = rnd37();
      if (resp_now && stubborn) begin
        tag_write_hit = 4'b0;
      end else if (resp_now) begin
        r = $urandom_range(0, 9);
        if (r < 3)
          tag_write_hit = 4'b0;
        else if (r < 8)
          tag_write_hit =
            4'(1 << $urandom_range(0, 3));
        else
          tag_write_hit =
            4'($urandom_range(1, 15));
      end else begin
        tag_write_hit = 4'($urandom());
      end
      smp();

      rdy_e = !busy && (mq.size() < 4);
      chk("r_wen", tag_write_wen, wen_e);
      chk("r_tinv", tag_invalidate,
          wen_e && r_inv);
      if (wen_e)
        chk("r_addr", tag_write_phys_addr, r_addr);
      chk("r_drop", drop, drop_e);
      chk("r_inv_rdy", inv_ready, rdy_e);
      chk("r_fill_rdy", fill_ready,
          rdy_e && !inv_valid);
      chk("r_expv", exp_valid, mq.size() != 0);
      if (mq.size() != 0)
        chk("r_expa", exp_addr, mq[0]);
      chk("r_multi", multi_hit, m_multi);

      nx_wen = 0;
      nx_drop = 0;
      if (mq.size() != 0 && exp_ready)
        void'(mq.pop_front());
      if (resp_now) begin
        if (tag_write_hit != 0) begin
          lw = lowest(tag_write_hit);
          if (tag_exp_en[lw])
            mq.push_back(tag_expun_addr[lw*37 +: 37]);
          if ($countones(tag_write_hit) > 1)
            m_multi = 1;
          busy = 0;
        end else if (tries < 16) begin
          tries++;
          nx_wen = 1;
        end else begin
          nx_drop = 1;
          busy = 0;
        end
      end else if (rdy_e &&
                   (inv_valid || fill_valid)) begin
        busy = 1;
        r_inv = inv_valid;
        r_addr = inv_valid ? inv_paddr : fill_paddr;
        tries = 1;
        nx_wen = 1;
        stubborn = ($urandom_range(0, 7) == 0);
      end
      resp_now = wen_e;
      wen_e = nx_wen;
      drop_e = nx_drop;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
